sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
Two-port controller that shares the single 8-bit sram (din/dout/addr/wr/rd/cs) between two requesters.
- Arbitrates round-robin and sequences each access as setup -> strobe -> done.
- Returns read data and a one-cycle ack per transaction.
- Sits between the sram instance and two client blocks, e.g. a host loader and a datapath engine.

Parameters:
DW, 8, data width (matches sram din/dout)
AW, 8, address width (matches sram addr)
WAIT_CYC, 1, number of cycles wr/rd strobe is held asserted; legal range 1..15

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 request; held high until ack0
we0  input  1  port 0: 1 = write, 0 = read; stable while req0
addr0  input  AW  port 0 address; stable while req0
wdata0  input  DW  port 0 write data; stable while req0
ack0  output  1  one-cycle pulse: port 0 transaction complete
rdata0  output  DW  port 0 read data; valid from ack0 and held until the next port 0 read completes
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
busy  output  1  high in any state other than IDLE
sram_cs  output  1  sram chip select, active high
sram_wr  output  1  sram write strobe, active high
sram_rd  output  1  sram read strobe, active high
sram_addr  output  AW  sram address
sram_din  output  DW  data to sram
sram_dout  input  DW  data from sram

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, and every output is 0: ack0/1, rdata0/1, busy, sram_cs, sram_wr, sram_rd, sram_addr, sram_din.
  - rr pointer set so port 0 wins the first tie.
- Reset mid-transaction: strobes and cs drop immediately; no ack is issued; the transaction is lost.
- All sram_* outputs are registered; no combinational path from req* to sram_*.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: sample req0/req1.
    - If any is high, grant one and latch its we/addr/wdata and owner id; go to SETUP.
    - Otherwise stay in IDLE.
  - SETUP (1 cycle): sram_cs=1, sram_addr=latched addr, sram_din=wdata for a write (0 for a read), strobes 0.
  - ACCESS (WAIT_CYC cycles, internal counter): cs=1, sram_wr=we, sram_rd=~we; addr and din unchanged.
    - For a read, sram_dout is captured into the owner's rdata on the edge ending the last ACCESS cycle.
  - DONE (1 cycle): cs/wr/rd=0, addr/din held; ack of the owner=1 for exactly this cycle. Next state is IDLE unconditionally.
- Latency: req sampled at edge E -> ack high during cycle E+2+WAIT_CYC. Min spacing between grants = 3+WAIT_CYC cycles (IDLE included).
- Arbitration:
  - Only one req high -> grant it.
  - Both high -> grant the port not served last. The pointer updates on grant.
  - A port cannot be starved: alternation is guaranteed under continuous contention.
- Handshake:
  - A requester holds req and its fields stable until it samples ack=1.
  - It may drop req or present a new request at that same edge; IDLE samples the updated value.
  - A req that stays high after ack is treated as a new transaction.
- A req rising while the FSM is not in IDLE waits; it is not lost.
- rdata of the non-owner port never changes. Writes never change either rdata.
- sram_wr and sram_rd are never high together; neither is ever high while sram_cs=0.

Decomposition:
- Shared include sram_ctrl_defs.vh: state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3), port ids PORT0/PORT1, WAIT_CYC legal bounds.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], load.
  - Outputs: gnt[1:0] one-hot, registered last-served pointer.
- FSM, counter and datapath latches stay in sram_arbiter.

Test Plan:
- Reset then single write, WAIT_CYC=1: req0=1, we0=1, addr0=8'h5A, wdata0=8'hA5 -> SETUP cs=1, addr=5A, din=A5; next cycle wr=1; ack0 pulses 3 cycles after req sampled; sram location 5A holds A5.
- Read-back: port 1 reads addr1=8'h5A -> rd=1 for one cycle, rdata1=8'hA5 when ack1 pulses; rdata0 stays 00.
- Contention: req0 and req1 both held high for 4 transactions from reset -> grant order 0,1,0,1; exactly one ack per 4-cycle transaction.
- WAIT_CYC=3: single read -> sram_rd high exactly 3 consecutive cycles; ack 5 cycles after req sampled.
- Reset mid-ACCESS: assert rst_n=0 while wr=1 -> cs/wr drop at once, no ack; after release, a pending req0 completes normally with port 0 winning.
- Protocol checker across random traffic (1000 transactions, random we/addr/data vs scoreboard model): never wr&rd; never wr|rd without cs; rdata matches model.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port sram arbiter: FSM encoding, port ids,
// and the legal strobe-length range.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The registered pointer remembers the last
// port served; on a tie the other port wins.
module rr_arb2 import sram_arbiter_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       load,
  output logic [1:0] gnt,
  output logic       last
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PORT0) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to PORT1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= PORT1;
    else if (load && (|gnt))
      last <= gnt[1];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram between two requesters: round-robin grant, then a
// setup -> strobe -> done sequence with a one-cycle ack to the owner.
module sram_arbiter import sram_arbiter_pkg::*; #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  if (WAIT_CYC < WAIT_MIN || WAIT_CYC > WAIT_MAX) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYC out of range");
  end

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xact_t;

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       cur_we;
  logic       owner;
  logic [1:0] gnt;
  logic       grant;
  xact_t      sel;

  assign grant = (state == IDLE) && (req0 || req1);

  // The arbiter's last-served pointer doubles as the owner of the
  // transaction in flight: it only moves on a grant.
  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({req1, req0}),
    .load (grant),
    .gnt  (gnt),
    .last (owner)
  );

  assign sel = gnt[1] ? {we1, addr1, wdata1} : {we0, addr0, wdata0};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Every output is a flop loaded from the next state, so nothing on the
  // sram side is combinationally reachable from the request inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_we    <= 1'b0;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      sram_cs   <= 1'b0;
      sram_wr   <= 1'b0;
      sram_rd   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx != IDLE);
      sram_cs <= (state_nx == SETUP) || (state_nx == ACCESS);
      sram_wr <= (state_nx == ACCESS) && cur_we;
      sram_rd <= (state_nx == ACCESS) && !cur_we;
      ack0    <= (state_nx == DONE) && (owner == PORT0);
      ack1    <= (state_nx == DONE) && (owner == PORT1);

      if (grant) begin
        cur_we    <= sel.we;
        sram_addr <= sel.addr;
        sram_din  <= sel.we ? sel.wdata : '0;
      end

      if (state == SETUP)
        cnt <= CNT_INIT;
      else if (state == ACCESS && cnt != '0)
        cnt <= cnt - 4'd1;

      if (state == ACCESS && cnt == '0 && !cur_we) begin
        if (owner == PORT1) rdata1 <= sram_dout;
        else                rdata0 <= sram_dout;
      end
    end
  end

endmodule
